cacheline_adaptor: RTL
======================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter s_line, default 256: cache line width in bits.
REQ-002 Parameter s_burst, default 64: physical memory beat width in bits; the number of beats per line (s_line/s_burst, 4 by default) SHALL be an integer.
REQ-003 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port line_i, input, s_line: line to write, from the eviction stage (pmem_wdata).
REQ-006 Port line_o, output, s_line: assembled read line, to the eviction stage (pmem_rdata).
REQ-007 Port address_i, input, 32: line address from the eviction stage (pmem_address).
REQ-008 Port read_i, input, 1: line read request; held high until resp_o.
REQ-009 Port write_i, input, 1: line write request; held high until resp_o.
REQ-010 Port resp_o, output, 1: one-cycle completion pulse to the eviction stage.
REQ-011 Port burst_i, input, s_burst: read beat from memory.
REQ-012 Port burst_o, output, s_burst: write beat to memory.
REQ-013 Port address_o, output, 32: burst address to memory.
REQ-014 Port read_o, output, 1: burst read request to memory.
REQ-015 Port write_o, output, 1: burst write request to memory.
REQ-016 Port resp_i, input, 1: memory beat-accept/valid strobe, one beat per high cycle.

Function
REQ-017 The state machine SHALL have four states: IDLE, READ, WRITE, DONE.
REQ-018 IDLE: if write_i is high, the block SHALL latch line_i and address_i, clear the beat counter, and go to WRITE; otherwise, if read_i is high, it SHALL latch address_i, clear the counter, and go to READ.
REQ-019 When read_i and write_i are high in the same cycle, write SHALL win and read SHALL be ignored until the next return to IDLE.
REQ-020 address_o SHALL be the latched address with bits [4:0] forced to 0; it SHALL be stable for the whole transaction.
REQ-021 READ: read_o SHALL be 1 (registered, first high the cycle after acceptance); on each cycle with resp_i=1, burst_i SHALL be stored into line slot [s_burst*cnt +: s_burst] and cnt incremented.
REQ-022 WRITE: write_o SHALL be 1; burst_o SHALL equal latched line slot cnt; each resp_i=1 cycle SHALL advance cnt.
REQ-023 The beat counter SHALL be 2 bits wide (log2 beats) and SHALL wrap to 0 on the final beat.
REQ-024 On the cycle resp_i accepts the last beat, the block SHALL go to DONE; read_o/write_o SHALL be 0 from the following cycle.
REQ-025 resp_i while in IDLE or DONE SHALL be ignored.
REQ-026 Non-consecutive resp_i (gaps) SHALL stall the counter with no data change.
REQ-027 DONE: resp_o SHALL be 1 for exactly this one cycle, line_o SHALL hold the assembled line (reads) and remain stable until the next read completes; the next state SHALL be IDLE unconditionally.
REQ-028 A request still high in the IDLE cycle after DONE SHALL be treated as a new request; the upstream stage SHALL deassert on resp_o.
REQ-029 read_o and write_o SHALL never be high simultaneously.
REQ-030 Minimum latency, request asserted to resp_o: beats + 2 cycles (6 by default) with back-to-back resp_i.

Reset
REQ-031 With rst high at a clock edge, the state SHALL go to IDLE and cnt to 0; read_o, write_o, resp_o SHALL be 0; line_o, burst_o, address_o SHALL be 0.
REQ-032 Reset mid-transaction SHALL abandon the burst with no resp_o; partial read data SHALL be discarded.

Verification
REQ-033 Read: address_i=0x0000_1234, read_i; resp_i high 4 consecutive cycles with burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220, one resp_o pulse, line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
REQ-034 Write: line_i = {D3,D2,D1,D0}, write_i, resp_i with one idle gap after beat 1 -> burst_o shows D0,D1,D1(held),D2,D3; resp_o a single cycle after D3.
REQ-035 Simultaneous read_i=write_i=1 -> only write_o asserted, read_o stays 0 throughout.
REQ-036 rst asserted after 2 read beats -> next cycle: all outputs 0, IDLE, no resp_o; a subsequent full read returns the correct line.
REQ-037 Stray resp_i in IDLE with burst_i=0xFFFF... -> no state change, line_o unchanged.
REQ-038 Back-to-back: read_i held one cycle past resp_o -> a second full read transaction starts; read_o/write_o never both 1.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Bridges a full cache line request to a sequence of s_burst-wide memory beats,
// assembling reads and serialising writes, with a one-cycle resp_o on completion.
module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,

    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS = s_line / s_burst;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [26:0]        addr_q, addr_d;
    logic [s_line-1:0]  wline_q, wline_d;
    logic [s_line-1:0]  rbuf_q, rbuf_d;
    logic [s_line-1:0]  line_q, line_d;
    logic               read_o_q, read_o_d;
    logic               write_o_q, write_o_d;
    logic               resp_o_q, resp_o_d;

    // Write takes priority over read; outputs are computed one cycle ahead so
    // that read_o/write_o/resp_o come straight from flops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wline_d   = wline_q;
        rbuf_d    = rbuf_q;
        line_d    = line_q;
        read_o_d  = 1'b0;
        write_o_d = 1'b0;
        resp_o_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (write_i) begin
                    addr_d    = address_i[31:5];
                    wline_d   = line_i;
                    cnt_d     = '0;
                    state_d   = WRITE;
                    write_o_d = 1'b1;
                end else if (read_i) begin
                    addr_d   = address_i[31:5];
                    cnt_d    = '0;
                    state_d  = READ;
                    read_o_d = 1'b1;
                end
            end
            READ: begin
                read_o_d = 1'b1;
                if (resp_i) begin
                    rbuf_d[int'(cnt_q)*s_burst +: s_burst] = burst_i;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d    = '0;
                        line_d   = rbuf_d;
                        state_d  = DONE;
                        read_o_d = 1'b0;
                        resp_o_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                write_o_d = 1'b1;
                if (resp_i) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d     = '0;
                        state_d   = DONE;
                        write_o_d = 1'b0;
                        resp_o_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wline_q   <= '0;
            line_q    <= '0;
            read_o_q  <= 1'b0;
            write_o_q <= 1'b0;
            resp_o_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wline_q   <= wline_d;
            line_q    <= line_d;
            read_o_q  <= read_o_d;
            write_o_q <= write_o_d;
            resp_o_q  <= resp_o_d;
        end
    end

    // Partial read data is never visible: line_o only loads on the final beat.
    always_ff @(posedge clk) begin
        rbuf_q <= rbuf_d;
    end

    assign line_o    = line_q;
    assign burst_o   = wline_q[int'(cnt_q)*s_burst +: s_burst];
    assign address_o = {addr_q, 5'b0};
    assign read_o    = read_o_q;
    assign write_o   = write_o_q;
    assign resp_o    = resp_o_q;

endmodule
